// File: rtl/event_discriminator_if.sv
// Sample stream into the discriminator and qualified-event results out of it.
// The discriminator is the master (drives the event side); the counter stage is the slave.
interface event_discriminator_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic signed [DATA_W-1:0] DataIn;
    logic                     EventStrobe;
    logic                     RejectStrobe;
    logic signed [DATA_W-1:0] EventPeak;
    logic        [CNT_W-1:0]  EventWidth;
    logic                     Busy;

    modport master (
        input  DataIn,
        output EventStrobe, RejectStrobe, EventPeak, EventWidth, Busy
    );

    modport slave (
        output DataIn,
        input  EventStrobe, RejectStrobe, EventPeak, EventWidth, Busy
    );
endinterface

// File: rtl/event_discriminator.sv
// Hysteresis threshold discriminator: qualifies pulses by minimum width, reports
// peak/width per event and enforces a dead time after each qualified event.
module event_discriminator #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Enable,
    input  logic signed [DATA_W-1:0] ThreshHigh,
    input  logic signed [DATA_W-1:0] ThreshLow,
    input  logic        [CNT_W-1:0]  MinWidth,
    input  logic        [CNT_W-1:0]  HoldOff,
    event_discriminator_if.master    bus
);
    typedef enum logic [1:0] {ARMED, PULSE, HOLDOFF} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                   state, state_n;
    logic signed [DATA_W-1:0] d_q;
    logic signed [DATA_W-1:0] peak, peak_n;
    logic signed [DATA_W-1:0] ev_peak, ev_peak_n;
    logic signed [DATA_W-1:0] release_lvl;
    logic        [CNT_W-1:0]  width, width_n;
    logic        [CNT_W-1:0]  hold, hold_n;
    logic        [CNT_W-1:0]  ev_width, ev_width_n;
    logic        [CNT_W-1:0]  min_eff;
    logic                     ev_q, ev_n;
    logic                     rj_q, rj_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Inverted thresholds collapse to a single level rather than an unreachable release.
    assign release_lvl = (ThreshLow < ThreshHigh) ? ThreshLow : ThreshHigh;
    assign min_eff     = (MinWidth == '0) ? CNT_ONE : MinWidth;

    always_comb begin
        state_n    = state;
        width_n    = width;
        peak_n     = peak;
        hold_n     = hold;
        ev_peak_n  = ev_peak;
        ev_width_n = ev_width;
        ev_n       = 1'b0;
        rj_n       = 1'b0;
        if (!Enable) begin
            state_n = ARMED;
        end else begin
            case (state)
                ARMED: begin
                    if (d_q >= ThreshHigh) begin
                        state_n = PULSE;
                        width_n = CNT_ONE;
                        peak_n  = d_q;
                    end
                end
                PULSE: begin
                    if (d_q >= release_lvl) begin
                        width_n = sat_inc(width);
                        peak_n  = smax(peak, d_q);
                    end else if (width >= min_eff) begin
                        ev_n       = 1'b1;
                        ev_peak_n  = peak;
                        ev_width_n = width;
                        hold_n     = CNT_ONE;
                        state_n    = (HoldOff == '0) ? ARMED : HOLDOFF;
                    end else begin
                        rj_n    = 1'b1;
                        state_n = ARMED;
                    end
                end
                HOLDOFF: begin
                    // The strobe cycle is the first counted dead-time cycle.
                    if (hold >= HoldOff) state_n = ARMED;
                    else                 hold_n  = sat_inc(hold);
                end
                default: state_n = ARMED;
            endcase
        end
    end

    // Stage p0 -> p1: sample capture and FSM/result registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ARMED;
            d_q      <= '0;
            width    <= '0;
            peak     <= '0;
            hold     <= '0;
            ev_peak  <= '0;
            ev_width <= '0;
            ev_q     <= 1'b0;
            rj_q     <= 1'b0;
        end else begin
            state    <= state_n;
            d_q      <= bus.DataIn;
            width    <= width_n;
            peak     <= peak_n;
            hold     <= hold_n;
            ev_peak  <= ev_peak_n;
            ev_width <= ev_width_n;
            ev_q     <= ev_n;
            rj_q     <= rj_n;
        end
    end

    assign bus.EventStrobe  = ev_q;
    assign bus.RejectStrobe = rj_q;
    assign bus.EventPeak    = ev_peak;
    assign bus.EventWidth   = ev_width;
    assign bus.Busy         = (state != ARMED);
endmodule

// File: tb/tb_event_discriminator.sv
// Directed-vector bench for event_discriminator with hand-computed expectations.
module tb_event_discriminator;
    logic               Clk = 1'b0;
    logic               Reset;
    logic               Enable;
    logic signed [15:0] ThreshHigh;
    logic signed [15:0] ThreshLow;
    logic [15:0]        MinWidth;
    logic [15:0]        HoldOff;

    int cmp = 0;
    int bad = 0;
    int ev_cnt = 0;
    int rj_cnt = 0;

    event_discriminator_if #(.DATA_W(16), .CNT_W(16)) bus ();

    event_discriminator #(.DATA_W(16), .CNT_W(16)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Enable     (Enable),
        .ThreshHigh (ThreshHigh),
        .ThreshLow  (ThreshLow),
        .MinWidth   (MinWidth),
        .HoldOff    (HoldOff),
        .bus        (bus)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
        if (bus.EventStrobe)  ev_cnt++;
        if (bus.RejectStrobe) rj_cnt++;
        cmp++;
        if (bus.EventStrobe && bus.RejectStrobe) begin
            bad++;
            $display("FAIL both_strobes: got ev=%b rj=%b, required not both", bus.EventStrobe, bus.RejectStrobe);
        end
    endtask

    task automatic idle(input int n);
        bus.DataIn = 16'sd0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        Enable = 1'b1; ThreshHigh = 16'sd500; ThreshLow = 16'sd200;
        MinWidth = 16'd3; HoldOff = 16'd10;
        bus.DataIn = 16'sd1000;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp++; if (bus.EventStrobe !== 1'b0) begin bad++; $display("FAIL rst_ev: got %b required 0", bus.EventStrobe); end
            cmp++; if (bus.RejectStrobe !== 1'b0) begin bad++; $display("FAIL rst_rj: got %b required 0", bus.RejectStrobe); end
            cmp++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", bus.Busy); end
            cmp++; if (bus.EventPeak !== 16'sd0) begin bad++; $display("FAIL rst_peak: got %0d required 0", bus.EventPeak); end
            cmp++; if (bus.EventWidth !== 16'd0) begin bad++; $display("FAIL rst_width: got %0d required 0", bus.EventWidth); end
        end
        bus.DataIn = 16'sd0;
        Reset = 1'b0;
        tick(); tick();
    endtask

    task automatic test_qualified();
        ev_cnt = 0; rj_cnt = 0;
        bus.DataIn = 16'sd600; tick();
        bus.DataIn = 16'sd900; tick();
        cmp++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL qual_busy_rise: got %b required 1", bus.Busy); end
        bus.DataIn = 16'sd700; tick();
        bus.DataIn = 16'sd300; tick();
        bus.DataIn = 16'sd100; tick();
        cmp++; if (bus.EventStrobe !== 1'b0) begin bad++; $display("FAIL qual_early: got %b required 0", bus.EventStrobe); end
        bus.DataIn = 16'sd0; tick();
        cmp++; if (bus.EventStrobe !== 1'b1) begin bad++; $display("FAIL qual_strobe: got %b required 1", bus.EventStrobe); end
        cmp++; if (bus.EventPeak !== 16'sd900) begin bad++; $display("FAIL qual_peak: got %0d required 900", bus.EventPeak); end
        cmp++; if (bus.EventWidth !== 16'd4) begin bad++; $display("FAIL qual_width: got %0d required 4", bus.EventWidth); end
        repeat (9) tick();
        cmp++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL qual_holdoff_busy: got %b required 1", bus.Busy); end
        tick();
        cmp++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL qual_holdoff_end: got %b required 0", bus.Busy); end
        cmp++; if (ev_cnt !== 1) begin bad++; $display("FAIL qual_ev_count: got %0d required 1", ev_cnt); end
        cmp++; if (rj_cnt !== 0) begin bad++; $display("FAIL qual_rj_count: got %0d required 0", rj_cnt); end
        idle(2);
    endtask

    task automatic test_reject();
        ev_cnt = 0; rj_cnt = 0;
        bus.DataIn = 16'sd600; tick();
        bus.DataIn = 16'sd100; tick();
        cmp++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL rej_busy: got %b required 1", bus.Busy); end
        bus.DataIn = 16'sd0; tick();
        cmp++; if (bus.RejectStrobe !== 1'b1) begin bad++; $display("FAIL rej_strobe: got %b required 1", bus.RejectStrobe); end
        cmp++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL rej_busy_fall: got %b required 0", bus.Busy); end
        cmp++; if (bus.EventPeak !== 16'sd900) begin bad++; $display("FAIL rej_peak_kept: got %0d required 900", bus.EventPeak); end
        cmp++; if (bus.EventWidth !== 16'd4) begin bad++; $display("FAIL rej_width_kept: got %0d required 4", bus.EventWidth); end
        tick();
        cmp++; if (bus.RejectStrobe !== 1'b0) begin bad++; $display("FAIL rej_one_cycle: got %b required 0", bus.RejectStrobe); end
        idle(3);
        cmp++; if (rj_cnt !== 1) begin bad++; $display("FAIL rej_rj_count: got %0d required 1", rj_cnt); end
        cmp++; if (ev_cnt !== 0) begin bad++; $display("FAIL rej_ev_count: got %0d required 0", ev_cnt); end
    endtask

    task automatic test_minwidth_zero();
        MinWidth = 16'd0; HoldOff = 16'd0;
        bus.DataIn = 16'sd600; tick();
        bus.DataIn = 16'sd100; tick();
        bus.DataIn = 16'sd0;   tick();
        cmp++; if (bus.EventStrobe !== 1'b1) begin bad++; $display("FAIL mw0_strobe: got %b required 1", bus.EventStrobe); end
        cmp++; if (bus.EventWidth !== 16'd1) begin bad++; $display("FAIL mw0_width: got %0d required 1", bus.EventWidth); end
        cmp++; if (bus.EventPeak !== 16'sd600) begin bad++; $display("FAIL mw0_peak: got %0d required 600", bus.EventPeak); end
        cmp++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL mw0_no_holdoff: got %b required 0", bus.Busy); end
        idle(3);
    endtask

    task automatic test_ringing();
        int ring[4]    = '{600, 150, 600, 150};
        int spaced[10] = '{600, 150, 0, 0, 0, 0, 0, 0, 600, 150};
        MinWidth = 16'd1; HoldOff = 16'd5; ThreshLow = 16'sd200;
        ev_cnt = 0; rj_cnt = 0;
        foreach (ring[i]) begin bus.DataIn = 16'(ring[i]); tick(); end
        idle(10);
        cmp++; if (ev_cnt !== 1) begin bad++; $display("FAIL ring_ho5: got %0d events required 1", ev_cnt); end
        ev_cnt = 0;
        foreach (spaced[i]) begin bus.DataIn = 16'(spaced[i]); tick(); end
        idle(10);
        cmp++; if (ev_cnt !== 2) begin bad++; $display("FAIL spaced_ho5: got %0d events required 2", ev_cnt); end
        HoldOff = 16'd20; ev_cnt = 0;
        foreach (spaced[i]) begin bus.DataIn = 16'(spaced[i]); tick(); end
        idle(25);
        cmp++; if (ev_cnt !== 1) begin bad++; $display("FAIL spaced_ho20: got %0d events required 1", ev_cnt); end
        cmp++; if (rj_cnt !== 0) begin bad++; $display("FAIL ring_rj: got %0d rejects required 0", rj_cnt); end
    endtask

    task automatic test_negative();
        bus.DataIn = -16'sd200; tick(); tick();
        ThreshHigh = -16'sd100; ThreshLow = 16'sd50; MinWidth = 16'd2; HoldOff = 16'd3;
        tick();
        ev_cnt = 0; rj_cnt = 0;
        bus.DataIn = -16'sd50;  tick();
        bus.DataIn = -16'sd20;  tick();
        bus.DataIn = -16'sd150; tick();
        tick();
        cmp++; if (bus.EventStrobe !== 1'b1) begin bad++; $display("FAIL neg_strobe: got %b required 1", bus.EventStrobe); end
        cmp++; if (bus.EventPeak !== -16'sd20) begin bad++; $display("FAIL neg_peak: got %0d required -20", bus.EventPeak); end
        cmp++; if (bus.EventWidth !== 16'd2) begin bad++; $display("FAIL neg_width: got %0d required 2", bus.EventWidth); end
        repeat (4) tick();
        ThreshHigh = 16'sd500; ThreshLow = 16'sd200;
        idle(2);
        cmp++; if (rj_cnt !== 0) begin bad++; $display("FAIL neg_rj: got %0d required 0", rj_cnt); end
        cmp++; if (ev_cnt !== 1) begin bad++; $display("FAIL neg_ev: got %0d required 1", ev_cnt); end
    endtask

    task automatic test_enable_drop();
        MinWidth = 16'd3; HoldOff = 16'd10;
        ev_cnt = 0; rj_cnt = 0;
        bus.DataIn = 16'sd600; tick();
        bus.DataIn = 16'sd700; tick();
        cmp++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL en_busy: got %b required 1", bus.Busy); end
        Enable = 1'b0; bus.DataIn = 16'sd800; tick();
        cmp++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL en_busy_drop: got %b required 0", bus.Busy); end
        cmp++; if (bus.EventStrobe !== 1'b0) begin bad++; $display("FAIL en_no_ev: got %b required 0", bus.EventStrobe); end
        cmp++; if (bus.RejectStrobe !== 1'b0) begin bad++; $display("FAIL en_no_rj: got %b required 0", bus.RejectStrobe); end
        Enable = 1'b1; bus.DataIn = 16'sd900; tick();
        cmp++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL en_restart: got %b required 1", bus.Busy); end
        tick();
        bus.DataIn = 16'sd100; tick();
        bus.DataIn = 16'sd0;   tick();
        cmp++; if (bus.EventStrobe !== 1'b1) begin bad++; $display("FAIL en_strobe: got %b required 1", bus.EventStrobe); end
        cmp++; if (bus.EventWidth !== 16'd3) begin bad++; $display("FAIL en_width: got %0d required 3", bus.EventWidth); end
        cmp++; if (bus.EventPeak !== 16'sd900) begin bad++; $display("FAIL en_peak: got %0d required 900", bus.EventPeak); end
        idle(12);
        cmp++; if (ev_cnt !== 1) begin bad++; $display("FAIL en_ev_count: got %0d required 1", ev_cnt); end
        cmp++; if (rj_cnt !== 0) begin bad++; $display("FAIL en_rj_count: got %0d required 0", rj_cnt); end
    endtask

    task automatic test_reset_mid();
        ev_cnt = 0; rj_cnt = 0;
        bus.DataIn = 16'sd600; tick();
        bus.DataIn = 16'sd700; tick();
        Reset = 1'b1; tick();
        cmp++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b required 0", bus.Busy); end
        cmp++; if (bus.EventPeak !== 16'sd0) begin bad++; $display("FAIL midrst_peak: got %0d required 0", bus.EventPeak); end
        cmp++; if (bus.EventWidth !== 16'd0) begin bad++; $display("FAIL midrst_width: got %0d required 0", bus.EventWidth); end
        Reset = 1'b0; bus.DataIn = 16'sd0;
        tick(); tick(); tick();
        cmp++; if (ev_cnt !== 0) begin bad++; $display("FAIL midrst_ev: got %0d required 0", ev_cnt); end
        cmp++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL midrst_idle: got %b required 0", bus.Busy); end
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b1; bus.DataIn = 16'sd0;
        ThreshHigh = 16'sd500; ThreshLow = 16'sd200; MinWidth = 16'd3; HoldOff = 16'd10;
        test_reset();
        test_qualified();
        test_reject();
        test_minwidth_zero();
        test_ringing();
        test_negative();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
